// File: rtl/hazard_pkg.sv
// Shared stage indices and the per-register scoreboard entry layout.
// Stage fields are STG_W bits wide, enough for pipelines of up to 15 post-ID stages.
package hazard_pkg;

    localparam int STG_W = 4;

    localparam logic [STG_W-1:0] STG_RF = STG_W'(0);
    localparam logic [STG_W-1:0] STG_EX = STG_W'(1);
    localparam logic [STG_W-1:0] STG_ME = STG_W'(2);
    localparam logic [STG_W-1:0] STG_WB = STG_W'(3);

    typedef struct packed {
        logic             valid;
        logic [STG_W-1:0] age;
        logic [STG_W-1:0] avail;
        logic             mc;
    } entry_t;

endpackage

// File: rtl/sb_entry.sv
// One register's producer record: written on issue, advanced one stage per
// unstalled cycle, cleared on retirement or flush.
module sb_entry
    import hazard_pkg::*;
#(
    parameter int NSTAGE      = 3,
    parameter int FLUSH_DEPTH = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             stall_ext,
    input  logic             flush,
    input  logic             mc_hold,
    input  logic             wr_en,
    input  logic [STG_W-1:0] wr_avail,
    input  logic             wr_mc,
    output entry_t           entry,
    output logic             valid_next
);

    localparam logic [STG_W-1:0] LAST = STG_W'(NSTAGE);
    localparam logic [STG_W-1:0] FD   = STG_W'(FLUSH_DEPTH);

    entry_t nxt;

    // A new write replaces the old producer even if that one is retiring this edge.
    always_comb begin
        nxt = entry;
        if (!stall_ext) begin
            if (wr_en) begin
                nxt.valid = 1'b1;
                nxt.age   = STG_EX;
                nxt.avail = wr_avail;
                nxt.mc    = wr_mc;
            end else if (entry.valid) begin
                if (flush && (entry.age <= FD)) begin
                    nxt = '0;
                end else if ((entry.age == STG_EX) && mc_hold) begin
                    nxt = entry;
                end else if (entry.age == LAST) begin
                    nxt = '0;
                end else begin
                    nxt.age = entry.age + STG_W'(1);
                end
            end
        end
    end

    assign valid_next = nxt.valid;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            entry <= '0;
        end else begin
            entry <= nxt;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Register scoreboard for an in-order pipeline: detects RAW hazards against
// in-flight producers, picks forwarding sources and holds ID behind multicycle ops.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NREG        = 32,
    parameter int NSTAGE      = 3,
    parameter int FLUSH_DEPTH = 2,
    parameter int AW          = $clog2(NREG),
    parameter int SW          = $clog2(NSTAGE + 1)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          stall_ext_i,
    input  logic          flush_i,
    input  logic          id_valid_i,
    input  logic [AW-1:0] id_rs_i,
    input  logic [AW-1:0] id_rt_i,
    input  logic          id_rs_used_i,
    input  logic          id_rt_used_i,
    input  logic          id_wr_i,
    input  logic [AW-1:0] id_wd_i,
    input  logic [SW-1:0] id_avail_i,
    input  logic          id_mc_i,
    input  logic          mc_done_i,
    output logic          issue_o,
    output logic          stall_id_o,
    output logic          bubble_ex_o,
    output logic [SW-1:0] fwd_a_o,
    output logic [SW-1:0] fwd_b_o,
    output logic [AW:0]   pending_o
);

    localparam logic [STG_W-1:0] LAST = STG_W'(NSTAGE);

    entry_t           tbl [NREG];
    logic [NREG-1:0]  vnext;
    logic [STG_W-1:0] avail_n;
    logic             flush_pend;
    logic             flush_eff;
    logic             raw_a, raw_b, hit_a, hit_b, hazard;
    logic             mc_hold;
    logic             issue;
    logic [AW:0]      cnt;

    // A flush that lands on a stalled cycle is remembered and applied on the next free cycle.
    assign flush_eff = flush_i | flush_pend;

    assign avail_n = ((id_avail_i == '0) || (STG_W'(id_avail_i) > LAST)) ? LAST
                                                                          : STG_W'(id_avail_i);

    assign raw_a = id_rs_used_i && (id_rs_i != '0) && tbl[id_rs_i].valid
                   && (tbl[id_rs_i].age < tbl[id_rs_i].avail);
    assign hit_a = id_rs_used_i && (id_rs_i != '0) && tbl[id_rs_i].valid
                   && (tbl[id_rs_i].age >= tbl[id_rs_i].avail);
    assign raw_b = id_rt_used_i && (id_rt_i != '0) && tbl[id_rt_i].valid
                   && (tbl[id_rt_i].age < tbl[id_rt_i].avail);
    assign hit_b = id_rt_used_i && (id_rt_i != '0) && tbl[id_rt_i].valid
                   && (tbl[id_rt_i].age >= tbl[id_rt_i].avail);
    assign hazard = raw_a | raw_b;

    always_comb begin
        mc_hold = 1'b0;
        cnt     = '0;
        for (int r = 0; r < NREG; r++) begin
            if (tbl[r].valid && tbl[r].mc && (tbl[r].age == STG_EX) && !mc_done_i) begin
                mc_hold = 1'b1;
            end
            cnt = cnt + (AW+1)'(vnext[r]);
        end
    end

    assign issue = id_valid_i & ~hazard & ~mc_hold & ~stall_ext_i & ~flush_eff;

    assign issue_o     = resetn & issue;
    assign stall_id_o  = resetn & ((id_valid_i & (hazard | mc_hold)) | stall_ext_i);
    assign bubble_ex_o = resetn & id_valid_i & hazard & ~mc_hold & ~stall_ext_i;
    assign fwd_a_o     = (resetn && hit_a) ? tbl[id_rs_i].age[SW-1:0] : '0;
    assign fwd_b_o     = (resetn && hit_b) ? tbl[id_rt_i].age[SW-1:0] : '0;

    assign tbl[0]   = '0;
    assign vnext[0] = 1'b0;

    for (genvar r = 1; r < NREG; r++) begin : g_entry
        sb_entry #(
            .NSTAGE      (NSTAGE),
            .FLUSH_DEPTH (FLUSH_DEPTH)
        ) u_entry (
            .clk        (clk),
            .resetn     (resetn),
            .stall_ext  (stall_ext_i),
            .flush      (flush_eff),
            .mc_hold    (mc_hold),
            .wr_en      (issue && id_wr_i && (id_wd_i == AW'(r))),
            .wr_avail   (avail_n),
            .wr_mc      (id_mc_i),
            .entry      (tbl[r]),
            .valid_next (vnext[r])
        );
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            flush_pend <= 1'b0;
            pending_o  <= '0;
        end else begin
            flush_pend <= stall_ext_i & flush_eff;
            pending_o  <= cnt;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: each stimulus cycle queues its expected
// outputs and an independent negedge monitor pops and compares them.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       stall_ext_i = 1'b0;
    logic       flush_i = 1'b0;
    logic       id_valid_i = 1'b0;
    logic [4:0] id_rs_i = '0;
    logic [4:0] id_rt_i = '0;
    logic       id_rs_used_i = 1'b0;
    logic       id_rt_used_i = 1'b0;
    logic       id_wr_i = 1'b0;
    logic [4:0] id_wd_i = '0;
    logic [1:0] id_avail_i = '0;
    logic       id_mc_i = 1'b0;
    logic       mc_done_i = 1'b0;
    logic       issue_o, stall_id_o, bubble_ex_o;
    logic [1:0] fwd_a_o, fwd_b_o;
    logic [5:0] pending_o;

    hazard_scoreboard dut (
        .clk          (clk),
        .resetn       (resetn),
        .stall_ext_i  (stall_ext_i),
        .flush_i      (flush_i),
        .id_valid_i   (id_valid_i),
        .id_rs_i      (id_rs_i),
        .id_rt_i      (id_rt_i),
        .id_rs_used_i (id_rs_used_i),
        .id_rt_used_i (id_rt_used_i),
        .id_wr_i      (id_wr_i),
        .id_wd_i      (id_wd_i),
        .id_avail_i   (id_avail_i),
        .id_mc_i      (id_mc_i),
        .mc_done_i    (mc_done_i),
        .issue_o      (issue_o),
        .stall_id_o   (stall_id_o),
        .bubble_ex_o  (bubble_ex_o),
        .fwd_a_o      (fwd_a_o),
        .fwd_b_o      (fwd_b_o),
        .pending_o    (pending_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic       issue;
        logic       stall;
        logic       bubble;
        logic [1:0] fa;
        logic [1:0] fb;
        logic [5:0] pend;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string tag, input string field, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s.%s actual=%0d expected=%0d", tag, field, act, exp);
        end
    endtask

    // Monitor: outputs are stable mid-cycle, between input update and the next rising edge.
    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.tag, "issue",   int'(issue_o),     int'(e.issue));
            chk(e.tag, "stall",   int'(stall_id_o),  int'(e.stall));
            chk(e.tag, "bubble",  int'(bubble_ex_o), int'(e.bubble));
            chk(e.tag, "fwd_a",   int'(fwd_a_o),     int'(e.fa));
            chk(e.tag, "fwd_b",   int'(fwd_b_o),     int'(e.fb));
            chk(e.tag, "pending", int'(pending_o),   int'(e.pend));
            if ($isunknown({issue_o, stall_id_o, bubble_ex_o, fwd_a_o, fwd_b_o, pending_o})) begin
                chk(e.tag, "unknown", 1, 0);
            end
        end
    end

    task automatic id_in(input logic v, input logic [4:0] rs, input logic ru,
                         input logic [4:0] rt, input logic tu, input logic w,
                         input logic [4:0] wd, input logic [1:0] av, input logic mc);
        id_valid_i = v;   id_rs_i = rs;  id_rs_used_i = ru;
        id_rt_i = rt;     id_rt_used_i = tu;
        id_wr_i = w;      id_wd_i = wd;  id_avail_i = av;  id_mc_i = mc;
    endtask

    task automatic idle();
        id_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        flush_i = 0;
        stall_ext_i = 0;
        mc_done_i = 0;
    endtask

    task automatic cyc(input string tag, input logic is, input logic st, input logic bu,
                       input logic [1:0] fa, input logic [1:0] fb, input logic [5:0] pe);
        exp_t e;
        e.tag = tag; e.issue = is; e.stall = st; e.bubble = bu;
        e.fa = fa; e.fb = fb; e.pend = pe;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        // Reset held with active inputs: every output forced low.
        id_in(1, 5, 1, 6, 1, 1, 5, 1, 0);
        stall_ext_i = 1;
        cyc("rst", 0, 0, 0, 0, 0, 0);
        resetn = 1;
        idle();
        cyc("idle", 0, 0, 0, 0, 0, 0);

        // ALU producer, avail in EX, forwarded to the next reader.
        id_in(1, 0, 0, 0, 0, 1, 5, 1, 0); cyc("s1_alu", 1, 0, 0, 0, 0, 0);
        id_in(1, 5, 1, 0, 0, 0, 0, 0, 0); cyc("s1_rd",  1, 0, 0, 1, 0, 1);
        idle();
        cyc("s1_me",   0, 0, 0, 0, 0, 1);
        cyc("s1_wb",   0, 0, 0, 0, 0, 1);
        cyc("s1_gone", 0, 0, 0, 0, 0, 0);

        // Load producer, avail in WB: two bubbles then forward from stage 3.
        id_in(1, 0, 0, 0, 0, 1, 6, 3, 0); cyc("s2_ld", 1, 0, 0, 0, 0, 0);
        id_in(1, 0, 0, 6, 1, 0, 0, 0, 0);
        cyc("s2_h1",  0, 1, 1, 0, 0, 1);
        cyc("s2_h2",  0, 1, 1, 0, 0, 1);
        cyc("s2_fwd", 1, 0, 0, 0, 3, 1);
        idle();
        cyc("s2_gone", 0, 0, 0, 0, 0, 0);

        // avail of 0 behaves as the last stage.
        id_in(1, 0, 0, 0, 0, 1, 15, 0, 0); cyc("av_wr", 1, 0, 0, 0, 0, 0);
        id_in(1, 15, 1, 0, 0, 0, 0, 0, 0);
        cyc("av_h1",  0, 1, 1, 0, 0, 1);
        cyc("av_h2",  0, 1, 1, 0, 0, 1);
        cyc("av_fwd", 1, 0, 0, 3, 0, 1);
        idle();
        cyc("av_gone", 0, 0, 0, 0, 0, 0);

        // Multicycle: div r0 leaves nothing; div r7 holds ID while r9/r10 retire.
        id_in(1, 0, 0, 0, 0, 1, 0, 1, 1);  cyc("s3_div0", 1, 0, 0, 0, 0, 0);
        id_in(1, 0, 0, 0, 0, 1, 9, 1, 0);  cyc("s3_r9",   1, 0, 0, 0, 0, 0);
        id_in(1, 0, 0, 0, 0, 1, 10, 1, 0); cyc("s3_r10",  1, 0, 0, 0, 0, 1);
        id_in(1, 0, 0, 0, 0, 1, 7, 1, 1);  cyc("s3_div7", 1, 0, 0, 0, 0, 2);
        id_in(1, 7, 1, 0, 0, 0, 0, 0, 0);
        mc_done_i = 0;
        cyc("s3_hold0", 0, 1, 0, 1, 0, 3);
        cyc("s3_hold1", 0, 1, 0, 1, 0, 2);
        for (int i = 2; i < 10; i++) begin
            cyc($sformatf("s3_hold%0d", i), 0, 1, 0, 1, 0, 1);
        end
        mc_done_i = 1;
        cyc("s3_done", 1, 0, 0, 1, 0, 1);
        idle();
        cyc("s3_me",   0, 0, 0, 0, 0, 1);
        cyc("s3_wb",   0, 0, 0, 0, 0, 1);
        cyc("s3_gone", 0, 0, 0, 0, 0, 0);

        // r8 rewritten as the old producer retires: youngest stays, then flushed.
        id_in(1, 0, 0, 0, 0, 1, 8, 1, 0); cyc("s4_w1", 1, 0, 0, 0, 0, 0);
        idle();
        cyc("s4_a2", 0, 0, 0, 0, 0, 1);
        cyc("s4_a3", 0, 0, 0, 0, 0, 1);
        id_in(1, 0, 0, 0, 0, 1, 8, 1, 0); cyc("s4_w2", 1, 0, 0, 0, 0, 1);
        id_in(1, 8, 1, 0, 0, 0, 0, 0, 0); cyc("s4_rd", 1, 0, 0, 1, 0, 1);
        flush_i = 1;
        cyc("s4_flush", 0, 0, 0, 2, 0, 1);
        idle();
        cyc("s4_after", 0, 0, 0, 0, 0, 0);

        // External stall freezes three entries; a flush raised during it lands afterwards.
        id_in(1, 0, 0, 0, 0, 1, 1, 1, 0); cyc("s5_w1", 1, 0, 0, 0, 0, 0);
        id_in(1, 0, 0, 0, 0, 1, 2, 1, 0); cyc("s5_w2", 1, 0, 0, 0, 0, 1);
        id_in(1, 0, 0, 0, 0, 1, 3, 1, 0); cyc("s5_w3", 1, 0, 0, 0, 0, 2);
        id_in(0, 1, 1, 3, 1, 0, 0, 0, 0);
        stall_ext_i = 1;
        for (int i = 0; i < 4; i++) begin
            cyc($sformatf("s5_stall%0d", i), 0, 1, 0, 3, 1, 3);
        end
        flush_i = 1;
        cyc("s5_stall_fl", 0, 1, 0, 3, 1, 3);
        stall_ext_i = 0;
        flush_i = 0;
        cyc("s5_deferred", 0, 0, 0, 3, 1, 3);
        cyc("s5_after",    0, 0, 0, 0, 0, 0);

        // Reset in the middle of a multicycle hold.
        idle();
        id_in(1, 0, 0, 0, 0, 1, 7, 1, 1); cyc("s6_div",  1, 0, 0, 0, 0, 0);
        id_in(1, 7, 1, 0, 0, 0, 0, 0, 0); cyc("s6_hold", 0, 1, 0, 1, 0, 1);
        resetn = 0;
        stall_ext_i = 1;
        cyc("s6_rst", 0, 0, 0, 0, 0, 0);
        resetn = 1;
        stall_ext_i = 0;
        cyc("s6_post", 1, 0, 0, 0, 0, 0);
        idle();
        cyc("s6_idle", 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 10 && q.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (q.size() != 0) begin
            chk("drain", "queue_left", q.size(), 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
